// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the MIPS32 core.
// Owns the PC and applies ID-resolved redirects, decode stalls and halt.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             ID_stall,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  input  logic             jump,
  input  logic [31:0]      jump_target,
  input  logic             JR,
  input  logic [31:0]      jr_target,
  input  logic             halt,
  output logic [31:0]      IF_ID_Instruction,
  output logic [31:0]      IF_ID_PCPlus4,
  output logic             IF_ID_valid,
  output logic [CNT_W-1:0] fetch_count,
  output logic [CNT_W-1:0] bubble_count
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      if_id_instr_q, if_id_instr_d;
  logic [31:0]      if_id_pc4_q, if_id_pc4_d;
  logic             if_id_valid_q, if_id_valid_d;
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] pc_plus4;

  // A redirect is only meaningful when ID holds a real instruction to resolve.
  assign redirect = if_id_valid_q & (JR | jump | branch_taken);
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    if (JR)        redirect_target = jr_target;
    else if (jump) redirect_target = jump_target;
    else           redirect_target = branch_target;
  end

  always_comb begin
    // NOTE: every signal gets its hold value first so no path can infer a latch.
    state_d       = state_q;
    pc_d          = pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_pc4_d   = if_id_pc4_q;
    if_id_valid_d = if_id_valid_q;
    fetch_cnt_d   = fetch_cnt_q;
    bubble_cnt_d  = bubble_cnt_q;

    unique case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (!ID_stall) begin
          if (redirect) begin
            // No delay slot: the word fetched this cycle is on the wrong path.
            pc_d          = redirect_target & 32'hFFFF_FFFC;
            if_id_instr_d = NOP_WORD;
            if_id_valid_d = 1'b0;
            bubble_cnt_d  = bubble_cnt_q + CNT_W'(1);
          end else begin
            pc_d          = pc_plus4;
            if_id_instr_d = imem_rdata;
            if_id_pc4_d   = pc_plus4;
            if_id_valid_d = 1'b1;
            fetch_cnt_d   = fetch_cnt_q + CNT_W'(1);
          end
          if (halt) state_d = HALTED;
        end
      end
      HALTED: begin
        if_id_valid_d = 1'b0;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      if_id_instr_q <= NOP_WORD;
      if_id_pc4_q   <= 32'd0;
      if_id_valid_q <= 1'b0;
      fetch_cnt_q   <= '0;
      bubble_cnt_q  <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc4_q   <= if_id_pc4_d;
      if_id_valid_q <= if_id_valid_d;
      fetch_cnt_q   <= fetch_cnt_d;
      bubble_cnt_q  <= bubble_cnt_d;
    end
  end

  assign imem_addr         = pc_q;
  assign IF_ID_Instruction = if_id_instr_q;
  assign IF_ID_PCPlus4     = if_id_pc4_q;
  assign IF_ID_valid       = if_id_valid_q;
  assign fetch_count       = fetch_cnt_q;
  assign bubble_count      = bubble_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by
// randomized stimulus compared every cycle against a behavioural model.
module tb_fetch_stage;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic [31:0] imem_addr, imem_rdata;
  logic        ID_stall = 1'b0, branch_taken = 1'b0, jump = 1'b0, JR = 1'b0, halt = 1'b0;
  logic [31:0] branch_target = '0, jump_target = '0, jr_target = '0;
  logic [31:0] IF_ID_Instruction, IF_ID_PCPlus4;
  logic        IF_ID_valid;
  logic [31:0] fetch_count, bubble_count;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_stage dut (
    .Clk(Clk), .Rst(Rst),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .ID_stall(ID_stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .JR(JR), .jr_target(jr_target),
    .halt(halt),
    .IF_ID_Instruction(IF_ID_Instruction), .IF_ID_PCPlus4(IF_ID_PCPlus4),
    .IF_ID_valid(IF_ID_valid),
    .fetch_count(fetch_count), .bubble_count(bubble_count)
  );

  always #5 Clk = ~Clk;

  // Instruction memory: each word is its own address plus 0x100.
  assign imem_rdata = imem_addr + 32'h100;

  // Reference model: 0 = waiting one cycle after reset, 1 = fetching, 2 = halted.
  int          m_mode;
  logic [31:0] m_pc, m_instr, m_pc4, m_fc, m_bc;
  logic        m_valid;

  task automatic model_reset();
    m_mode = 0; m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
    m_valid = 1'b0; m_fc = 0; m_bc = 0;
  endtask

  task automatic model_step();
    logic [31:0] tgt;
    if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 2) begin
      m_valid = 1'b0;
    end else if (!ID_stall) begin
      if (m_valid && (JR || jump || branch_taken)) begin
        tgt     = JR ? jr_target : (jump ? jump_target : branch_target);
        m_pc    = {tgt[31:2], 2'b00};
        m_instr = 32'h0;
        m_valid = 1'b0;
        m_bc    = m_bc + 1;
      end else begin
        m_instr = m_pc + 32'h100;
        m_pc4   = m_pc + 4;
        m_pc    = m_pc + 4;
        m_valid = 1'b1;
        m_fc    = m_fc + 1;
      end
      if (halt) m_mode = 2;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".addr"},  imem_addr,            m_pc);
    check({tag, ".instr"}, IF_ID_Instruction,    m_instr);
    check({tag, ".pc4"},   IF_ID_PCPlus4,        m_pc4);
    check({tag, ".valid"}, {31'd0, IF_ID_valid}, {31'd0, m_valid});
    check({tag, ".fcnt"},  fetch_count,          m_fc);
    check({tag, ".bcnt"},  bubble_count,         m_bc);
  endtask

  task automatic set_in(input logic st, input logic br, input logic [31:0] bt,
                        input logic j, input logic [31:0] jt,
                        input logic r, input logic [31:0] rt, input logic h);
    ID_stall = st; branch_taken = br; branch_target = bt;
    jump = j; jump_target = jt; JR = r; jr_target = rt; halt = h;
  endtask

  // Inputs are applied just after a rising edge; outputs are sampled 1ns after the next one.
  task automatic step(input string tag);
    model_step();
    @(posedge Clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    step(tag);
  endtask

  // Drop reset away from any clock edge, check it acts at once, then release.
  task automatic async_reset(input string tag);
    #3;
    Rst = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge Clk);
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    model_step();
    check_all({tag, ".boot"});
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    @(negedge Clk);
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    model_step();
    check_all("boot1");
    check("boot1.valid0", {31'd0, IF_ID_valid}, 32'd0);
    idle("boot2");
    check("boot2.instr", IF_ID_Instruction, 32'h100);
    check("boot2.pc4", IF_ID_PCPlus4, 32'h4);
    idle("boot3");
    check("boot3.instr", IF_ID_Instruction, 32'h104);
    check("boot3.fcnt", fetch_count, 32'd2);

    // Stall at PC=0x10, with a redirect asserted that must be ignored.
    while (m_pc != 32'h10) idle("to10");
    set_in(1, 0, 0, 0, 0, 0, 0, 0); step("stall1");
    set_in(1, 1, 32'h300, 0, 0, 0, 0, 0); step("stall2");
    set_in(1, 0, 0, 0, 0, 0, 0, 0); step("stall3");
    check("stall.addr", imem_addr, 32'h10);
    idle("unstall");
    check("unstall.instr", IF_ID_Instruction, 32'h110);
    check("unstall.pc4", IF_ID_PCPlus4, 32'h14);

    // Branch redirect.
    set_in(0, 1, 32'h40, 0, 0, 0, 0, 0); step("branch");
    check("branch.addr", imem_addr, 32'h40);
    check("branch.bcnt", bubble_count, 32'd1);
    idle("branch_tgt");
    check("branch_tgt.pc4", IF_ID_PCPlus4, 32'h44);

    // Priority JR > jump > branch, then redirect while valid=0 is ignored.
    set_in(0, 1, 32'h300, 1, 32'h200, 1, 32'h80, 0); step("prio");
    check("prio.addr", imem_addr, 32'h80);
    set_in(0, 0, 0, 1, 32'h200, 0, 0, 0); step("masked");
    check("masked.addr", imem_addr, 32'h84);

    // PC wrap and target alignment.
    set_in(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF, 0); step("jr_top");
    check("jr_top.addr", imem_addr, 32'hFFFF_FFFC);
    idle("wrap");
    check("wrap.pc4", IF_ID_PCPlus4, 32'h0);
    check("wrap.addr", imem_addr, 32'h0);
    set_in(0, 0, 0, 0, 0, 1, 32'h83, 0); step("align");
    check("align.addr", imem_addr, 32'h80);

    // Halt at PC=0x20.
    idle("pre_halt");
    set_in(0, 0, 0, 0, 0, 1, 32'h20, 0); step("to20");
    set_in(0, 0, 0, 0, 0, 0, 0, 1); step("halt");
    check("halt.instr", IF_ID_Instruction, 32'h120);
    for (int i = 0; i < 4; i++) idle("halted");
    check("halted.addr", imem_addr, 32'h24);
    check("halted.valid", {31'd0, IF_ID_valid}, 32'd0);

    async_reset("areset");

    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      set_in($urandom_range(3) == 0, $urandom_range(5) == 0, $urandom,
             $urandom_range(7) == 0, $urandom, $urandom_range(9) == 0, $urandom,
             $urandom_range(99) == 0);
      step("rand");
      if (m_mode == 2 && $urandom_range(9) == 0) async_reset("rand_reset");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the MIPS32 core.
- Sits directly upstream of decode and the control unit.
- Holds the PC and drives the instruction-memory address.
- Applies redirects (branch, J/JAL, JR) resolved in ID, honours the decode stall, and presents fetched instructions to ID with a valid bit, plus fetch/bubble counters.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_WORD, 32'h0000_0000, instruction word presented to ID when IF_ID_valid=0
CNT_W, 32, width of performance counters

Ports:
Clk  in  1  clock, all state updates on rising edge
Rst  in  1  asynchronous active-low reset
imem_addr  out  32  byte address to instruction memory (= PC)
imem_rdata  in  32  instruction word, combinational from imem_addr
ID_stall  in  1  hazard stall from decode control
branch_taken  in  1  conditional branch in ID resolved taken
branch_target  in  32  branch target address
jump  in  1  J or JAL in ID
jump_target  in  32  jump target address
JR  in  1  JR in ID
jr_target  in  32  register value for JR
halt  in  1  stop fetching after current cycle
IF_ID_Instruction  out  32  registered instruction to ID
IF_ID_PCPlus4  out  32  registered PC+4 of that instruction
IF_ID_valid  out  1  IF_ID_Instruction is a real instruction
fetch_count  out  CNT_W  instructions delivered to ID
bubble_count  out  CNT_W  bubbles inserted due to redirect

Behaviour:
- Reset (Rst=0, async):
  - PC=RESET_PC; state=BOOT.
  - IF_ID_Instruction=NOP_WORD; IF_ID_PCPlus4=0; IF_ID_valid=0; both counters=0.
- States:
  - BOOT: one cycle after reset release. PC held, no fetch latched, valid=0. Goes to RUN.
  - RUN: normal fetch.
  - HALTED: PC and IF/ID frozen with valid=0; exit only via reset.
- imem_addr = PC at all times. PC[1:0] always 00: targets are used with their low two bits forced to 0.
- Redirect request R = branch_taken | jump | JR. Only one is expected at a time; if several are asserted, priority is JR > jump > branch_taken.
- Per-cycle priority in RUN:
  1. ID_stall=1: PC, IF_ID_* and counters hold. Redirect inputs are ignored, because the ID instruction is not yet valid to resolve.
  2. R=1 (no stall): PC <= selected target; IF_ID_Instruction <= NOP_WORD; IF_ID_valid <= 0; bubble_count++. No delay slot: the wrong-path fetch is squashed.
  3. Otherwise: IF_ID_Instruction <= imem_rdata; IF_ID_PCPlus4 <= PC+4; IF_ID_valid <= 1; PC <= PC+4; fetch_count++.
- Redirect inputs are qualified internally with IF_ID_valid: an input asserted while IF_ID_valid=0 is ignored.
- halt=1 in RUN with no stall: the current cycle still executes rule 2 or 3, then state goes to HALTED. halt during a stall is deferred until the stall clears.
- PC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0). Counters wrap silently at 2^CNT_W.
- Reset asserted mid-operation clears everything immediately, independent of Clk.
- Latency: an instruction appears on IF_ID_* one cycle after its PC is on imem_addr. A redirect target's instruction is valid in ID two cycles after the redirect cycle.

Test Plan:
- Reset/boot: Rst low then high; imem returns addr+0x100 -> cycle 1 valid=0, PC=0. Cycle 2 IF_ID_Instruction=0x100, PCPlus4=4, valid=1. Cycle 3 instruction=0x104, fetch_count=2.
- Stall: assert ID_stall 3 cycles while PC=0x10 -> PC, IF_ID_Instruction, fetch_count unchanged. Release -> next latched word from 0x10, PCPlus4=0x14.
- Branch redirect: IF_ID_valid=1, branch_taken=1, target 0x40 -> next cycle valid=0, bubble_count=1, imem_addr=0x40. Following cycle PCPlus4=0x44.
- Priority and masking: JR=1 (0x80), jump=1 (0x200), branch_taken=1 together -> PC=0x80. Redirect asserted with ID_stall=1 -> ignored, PC holds. Redirect with valid=0 -> ignored.
- Wrap and alignment: PC=32'hFFFF_FFFC, no redirect -> PCPlus4=0, PC=0. jr_target=0x83 -> PC=0x80.
- Halt and async reset: halt pulsed at PC=0x20 -> that fetch completes, then PC stays 0x24 with valid=0 indefinitely. Rst dropped mid-clock -> all outputs reset without waiting for an edge.
